// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch buffer entry type
package cpu_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_buf.sv
// rtl/ifu_buf.sv - in-order fetch buffer with alloc, fill and head pointers
module ifu_buf
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            alloc_en,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill_en,
    input  logic [XLEN-1:0] fill_inst,
    input  logic            pop_en,
    output logic            head_valid,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_inst,
    output logic [AW:0]     count,
    output logic [AW:0]     unfilled
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    fetch_entry_t entries [DEPTH];
    fetch_entry_t head_entry;
    logic [AW:0]  alloc_ptr;
    logic [AW:0]  fill_ptr;
    logic [AW:0]  head_ptr;

    // Extra wrap bit on each pointer makes full and empty distinguishable.
    assign count      = alloc_ptr - head_ptr;
    assign unfilled   = alloc_ptr - fill_ptr;
    assign head_entry = entries[head_ptr[AW-1:0]];
    assign head_valid = (count != '0) && head_entry.filled;
    assign head_pc    = head_entry.pc;
    assign head_inst  = head_entry.inst;

    // Pointer advance and entry writes; flush only rewinds pointers because allocation rewrites the filled bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
        end else begin
            if (alloc_en) begin
                entries[alloc_ptr[AW-1:0]] <= '{pc: alloc_pc, inst: INST_NOP, filled: 1'b0};
                alloc_ptr                  <= alloc_ptr + PTR_ONE;
            end
            if (fill_en) begin
                entries[fill_ptr[AW-1:0]].inst   <= fill_inst;
                entries[fill_ptr[AW-1:0]].filled <= 1'b1;
                fill_ptr                         <= fill_ptr + PTR_ONE;
            end
            if (pop_en) begin
                head_ptr <= head_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - fetch PC sequencing, imem handshake and redirect flush; optional IFU_MISALIGN_EXC_EN
module ifu_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] inst
`ifdef IFU_MISALIGN_EXC_EN
    ,
    output logic            misalign_err
`endif
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] redirect_load;
    logic [AW:0]     drop_cnt;
    logic [AW:0]     drop_flush;
    logic [AW:0]     rsp_dec;
    logic [AW:0]     count;
    logic [AW:0]     unfilled;
    logic            halted;
    logic            req_fire;
    logic            rsp_fill;
    logic            pop_fire;

    // Slots are reserved at request time, so stale responses still occupy capacity until they return.
    assign imem_req_valid = rst_n && !redirect_valid && !halted &&
                            (({1'b0, count} + {1'b0, drop_cnt}) < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fill       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign pop_fire       = inst_valid && inst_ready && !redirect_valid;

    // On redirect every allocated-but-unfilled entry becomes a response to discard, less one landing now.
    assign rsp_dec    = {{AW{1'b0}}, imem_rsp_valid};
    assign drop_flush = drop_cnt + unfilled - rsp_dec;

`ifdef IFU_MISALIGN_EXC_EN
    assign halted        = misalign_err;
    assign redirect_load = redirect_pc;

    // Sticky misalignment flag, re-evaluated on every redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            misalign_err <= |redirect_pc[1:0];
        end
    end
`else
    assign halted        = 1'b0;
    assign redirect_load = redirect_pc & 32'hFFFF_FFFC;
`endif

    // Fetch PC advance and stale-response counter; redirect overrides everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_load;
            drop_cnt <= drop_flush;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - PTR_ONE;
            end
        end
    end

    ifu_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .alloc_en   (req_fire),
        .alloc_pc   (fetch_pc),
        .fill_en    (rsp_fill),
        .fill_inst  (imem_rsp_data),
        .pop_en     (pop_fire),
        .head_valid (inst_valid),
        .head_pc    (pc),
        .head_inst  (inst),
        .count      (count),
        .unfilled   (unfilled)
    );

endmodule
